// File: rtl/img_pkg.sv
// Shared image geometry, pixel type and framer state encoding
// for the rotation output path.
package img_pkg;

  localparam int unsigned DEF_IMG_W   = 512;
  localparam int unsigned DEF_IMG_H   = 512;
  localparam int unsigned PIX_DW      = 8;
  localparam int unsigned DEF_PIX_CNT = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [PIX_DW-1:0] pix_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO. The head entry is re-presented on registered
// outputs, so occupancy counts the entry currently on the output.
module pix_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_valid_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_avail;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          w_pop;
  logic          w_push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_pop        = i_pop && r_valid;
    w_push       = i_push && ((r_count < CW'(DEPTH)) || w_pop);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_avail      = r_count - CW'(w_pop);
    w_count_nxt  = w_avail + CW'(w_push);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Head register only sees entries written before this edge: 1-cycle latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_avail != '0);
      if (w_avail != '0) begin
        r_data <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_full        = (r_count == CW'(DEPTH));
  assign o_empty       = (r_count == '0);
  assign o_valid_nxt_c = (w_avail != '0);

endmodule

// File: rtl/rot_out_framer.sv
// Buffers the rotation adapter's free-running pixel stream and re-emits it
// as a valid/ready raster stream with SOF/EOL/EOF flags and drop detection.
module rot_out_framer #(
  parameter int unsigned IMG_W      = img_pkg::DEF_IMG_W,
  parameter int unsigned IMG_H      = img_pkg::DEF_IMG_H,
  parameter int unsigned DW         = img_pkg::PIX_DW,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_pix_in,
  input  logic          i_pix_valid,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic          o_m_sof,
  output logic          o_m_eol,
  output logic          o_m_eof,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_overflow
);

  import img_pkg::*;

  localparam int unsigned PIX   = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(PIX) + 1;
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_in_cnt;
  logic [XW-1:0]    r_x;
  logic [XW-1:0]    w_x_nxt;
  logic [YW-1:0]    r_y;
  logic [YW-1:0]    w_y_nxt;
  logic             w_clr;
  logic             w_cap;
  logic             w_last_in;
  logic             w_drop;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_head_valid;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [DW-1:0]    w_head_data;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  pix_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_cap),
    .i_data        (i_pix_in),
    .i_pop         (i_m_ready),
    .o_data        (w_head_data),
    .o_valid       (w_head_valid),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_valid_nxt_c (w_valid_nxt)
  );

  assign w_pop     = w_head_valid && i_m_ready;
  assign w_last_in = w_cap && (r_in_cnt == CNT_W'(PIX - 1));
  assign w_drop    = w_cap && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture only in RUN, so a pixel coincident with start is not taken.
  always_comb begin
    w_clr      = 1'b0;
    w_cap      = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_clr      = (r_state == S_IDLE) && i_start;
    w_cap      = (r_state == S_RUN) && i_pix_valid;
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Raster position of the beat that will be on the output after this edge.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_clr) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (w_pop) begin
      if (r_x == XW'(IMG_W - 1)) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == YW'(IMG_H - 1)) ? '0 : r_y + YW'(1);
      end else begin
        w_x_nxt = r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_cnt <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_eof    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_clr) begin
        r_in_cnt <= '0;
      end else if (w_cap) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_sof  <= w_valid_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
      r_eol  <= w_valid_nxt && (w_x_nxt == XW'(IMG_W - 1));
      r_eof  <= w_valid_nxt && (w_x_nxt == XW'(IMG_W - 1)) && (w_y_nxt == YW'(IMG_H - 1));
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_clr) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_m_data     = w_head_data;
  assign o_m_valid    = w_head_valid;
  assign o_m_sof      = r_sof;
  assign o_m_eol      = r_eol;
  assign o_m_eof      = r_eof;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_rot_out_framer.sv
// Scoreboard bench for rot_out_framer: three small geometries cover reset,
// back-pressure, overflow, full-with-pop, start misuse and random traffic.
module tb_rot_out_framer;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_start, a_pv, a_ready, a_valid, a_sof, a_eol, a_eof, a_busy, a_done, a_ovf;
  logic [7:0] a_pix, a_data;
  logic       b_start, b_pv, b_ready, b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_ovf;
  logic [7:0] b_pix, b_data;
  logic       c_start, c_pv, c_ready, c_valid, c_sof, c_eol, c_eof, c_busy, c_done, c_ovf;
  logic [7:0] c_pix, c_data;

  rot_out_framer #(.IMG_W(4), .IMG_H(2), .DW(8), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_pix_in(a_pix), .i_pix_valid(a_pv),
    .o_m_data(a_data), .o_m_valid(a_valid), .i_m_ready(a_ready), .o_m_sof(a_sof),
    .o_m_eol(a_eol), .o_m_eof(a_eof), .o_busy(a_busy), .o_frame_done(a_done),
    .o_overflow(a_ovf));

  rot_out_framer #(.IMG_W(4), .IMG_H(8), .DW(8), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_pix_in(b_pix), .i_pix_valid(b_pv),
    .o_m_data(b_data), .o_m_valid(b_valid), .i_m_ready(b_ready), .o_m_sof(b_sof),
    .o_m_eol(b_eol), .o_m_eof(b_eof), .o_busy(b_busy), .o_frame_done(b_done),
    .o_overflow(b_ovf));

  rot_out_framer #(.IMG_W(16), .IMG_H(8), .DW(8), .FIFO_DEPTH(16)) dut_c (
    .clk(clk), .rst(rst), .i_start(c_start), .i_pix_in(c_pix), .i_pix_valid(c_pv),
    .o_m_data(c_data), .o_m_valid(c_valid), .i_m_ready(c_ready), .o_m_sof(c_sof),
    .o_m_eol(c_eol), .o_m_eof(c_eof), .o_busy(c_busy), .o_frame_done(c_done),
    .o_overflow(c_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int k, input int w, input int h, input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.f = {k == 0, (k % w) == w - 1, k == w * h - 1};
    return e;
  endfunction

  exp_t qa[$], qb[$], qc[$];
  int a_beats = 0, a_dones = 0, b_beats = 0, b_dones = 0, b_eofs = 0;
  int c_beats = 0, c_dones = 0, c_sofs = 0, c_eols = 0, c_eofs = 0;
  logic a_stall = 0, b_stall = 0, c_stall = 0;
  logic [7:0] a_hold, b_hold, c_hold;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      a_stall = 0; b_stall = 0; c_stall = 0;
    end else begin
      if (a_stall) check("a_hold_data", {a_valid, a_data}, {1'b1, a_hold});
      if (!a_valid) check("a_flag_qual", {a_sof, a_eol, a_eof}, 0);
      else if (a_ready) begin
        a_beats++;
        if (qa.size() == 0) check("a_extra_beat", a_data, 32'hFFFF_FFFF);
        else begin
          e = qa.pop_front();
          check("a_data", a_data, e.d);
          check("a_flags", {a_sof, a_eol, a_eof}, e.f);
        end
      end
      a_stall = a_valid && !a_ready; a_hold = a_data;
      if (a_done) a_dones++;

      if (b_stall) check("b_hold_data", {b_valid, b_data}, {1'b1, b_hold});
      if (!b_valid) check("b_flag_qual", {b_sof, b_eol, b_eof}, 0);
      else if (b_ready) begin
        b_beats++;
        if (b_eof) b_eofs++;
        if (qb.size() == 0) check("b_extra_beat", b_data, 32'hFFFF_FFFF);
        else begin
          e = qb.pop_front();
          check("b_data", b_data, e.d);
          check("b_flags", {b_sof, b_eol, b_eof}, e.f);
        end
      end
      b_stall = b_valid && !b_ready; b_hold = b_data;
      if (b_done) b_dones++;

      if (c_stall) check("c_hold_data", {c_valid, c_data}, {1'b1, c_hold});
      if (c_valid && c_ready) begin
        c_beats++;
        if (c_sof) c_sofs++;
        if (c_eol) c_eols++;
        if (c_eof) c_eofs++;
        if (qc.size() == 0) check("c_extra_beat", c_data, 32'hFFFF_FFFF);
        else begin
          e = qc.pop_front();
          check("c_data", c_data, e.d);
          check("c_flags", {c_sof, c_eol, c_eof}, e.f);
        end
      end
      c_stall = c_valid && !c_ready; c_hold = c_data;
      if (c_done) c_dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dones(input int s);
    case (s)
      0:       return a_dones;
      1:       return b_dones;
      default: return c_dones;
    endcase
  endfunction

  task automatic wait_done(input int s, input int budget, input string tag);
    int n0 = dones(s);
    int i = 0;
    while (dones(s) == n0 && i < budget) begin
      tick();
      i++;
    end
    check(tag, dones(s) - n0, 1);
    repeat (3) tick();
    check({tag, "_once"}, dones(s) - n0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b0, sent, cyc;
    a_start = 0; a_pv = 0; a_ready = 0; a_pix = 0;
    b_start = 0; b_pv = 0; b_ready = 0; b_pix = 0;
    c_start = 0; c_pv = 0; c_ready = 0; c_pix = 0;
    repeat (3) tick();
    check("a_reset_outs", {a_valid, a_data, a_sof, a_eol, a_eof, a_busy, a_done, a_ovf}, 0);
    check("b_reset_outs", {b_valid, b_data, b_sof, b_eol, b_eof, b_busy, b_done, b_ovf}, 0);
    rst = 1;
    tick();

    // Reset in the middle of RUN aborts the frame without frame_done
    a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < 3; i++) begin a_pv = 1; a_pix = 8'(8'hA0 + i); tick(); end
    a_pv = 0;
    check("a_busy_mid_run", a_busy, 1);
    #2 rst = 0;
    #1 check("a_async_reset", {a_valid, a_data, a_sof, a_eol, a_eof, a_busy, a_ovf}, 0);
    tick(); rst = 1;
    repeat (3) tick();
    check("a_no_done_on_abort", a_dones, 0);

    // Start coincident with a pixel: that pixel is skipped
    a_ready = 1; a_start = 1; a_pv = 1; a_pix = 8'hEE; tick();
    a_start = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      a_pix = 8'(i); qa.push_back(mk(k, 4, 2, 8'(i))); k++; tick();
    end
    a_pv = 0;
    wait_done(0, 50, "a_done_t1");
    check("a_beats_t1", a_beats, 8);
    check("a_ovf_t1", a_ovf, 0);
    check("a_queue_t1", qa.size(), 0);

    // Back-pressure within depth
    b0 = a_beats; a_ready = 0; a_start = 1; tick(); a_start = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      a_pv = 1; a_pix = 8'(8'h10 + i); qa.push_back(mk(k, 4, 2, 8'(8'h10 + i))); k++; tick();
    end
    a_pv = 0;
    repeat (4) tick();
    check("a_stalled_valid", a_valid, 1);
    check("a_busy_drain", a_busy, 1);
    a_ready = 1;
    wait_done(0, 50, "a_done_t2");
    check("a_beats_t2", a_beats - b0, 8);
    check("a_ovf_t2", a_ovf, 0);

    // Start during RUN is ignored; the frame still ends after 8 pixels
    b0 = a_beats; a_start = 1; tick(); a_start = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      a_pv = 1; a_pix = 8'(8'h20 + i); a_start = (i == 3);
      qa.push_back(mk(k, 4, 2, 8'(8'h20 + i))); k++; tick();
    end
    a_pv = 0; a_start = 0;
    wait_done(0, 30, "a_done_t3");
    check("a_beats_t3", a_beats - b0, 8);

    // pix_valid while IDLE produces nothing
    b0 = a_beats;
    for (int i = 0; i < 4; i++) begin a_pv = 1; a_pix = 8'(8'h30 + i); tick(); end
    a_pv = 0;
    repeat (5) tick();
    check("a_idle_no_beats", a_beats - b0, 0);
    check("a_idle_not_busy", {a_busy, a_valid}, 0);

    // Overflow: depth 4, sink stalled for the whole frame
    b_ready = 0; b_start = 1; tick(); b_start = 0; k = 0;
    for (int i = 0; i < 32; i++) begin
      b_pv = 1; b_pix = 8'(i);
      if (i < 4) begin qb.push_back(mk(k, 4, 8, 8'(i))); k++; end
      tick();
    end
    b_pv = 0;
    check("b_ovf_set", b_ovf, 1);
    check("b_busy_drain", b_busy, 1);
    b_ready = 1;
    wait_done(1, 50, "b_done_ovf");
    check("b_beats_ovf", b_beats, 4);
    check("b_no_eof_ovf", b_eofs, 0);
    check("b_ovf_sticky", b_ovf, 1);

    // Full FIFO with simultaneous push and pop
    b0 = b_beats; b_ready = 0; b_start = 1; tick(); b_start = 0; k = 0;
    check("b_ovf_cleared", b_ovf, 0);
    for (int i = 0; i < 32; i++) begin
      b_pv = 1; b_pix = 8'(8'h40 + i); b_ready = (i >= 4);
      qb.push_back(mk(k, 4, 8, 8'(8'h40 + i))); k++; tick();
      if (i == 4) begin
        check("b_full_pop_count", dut_b.u_fifo.r_count, 4);
        check("b_full_pop_ovf", b_ovf, 0);
      end
    end
    b_pv = 0;
    wait_done(1, 50, "b_done_full");
    check("b_beats_full", b_beats - b0, 32);
    check("b_eof_full", b_eofs, 1);
    check("b_ovf_full", b_ovf, 0);

    // Random traffic: two 16x8 frames, random gaps and random back-pressure
    for (int f = 0; f < 2; f++) begin
      c_beats = 0; c_sofs = 0; c_eols = 0; c_eofs = 0;
      c_start = 1; tick(); c_start = 0;
      sent = 0; k = 0; cyc = 0;
      while (sent < 128 && cyc < 2000) begin
        c_pv = ($urandom_range(0, 9) < 7);
        c_pix = 8'($urandom);
        if (c_pv) begin qc.push_back(mk(k, 16, 8, c_pix)); k++; sent++; end
        c_ready = ($urandom_range(0, 3) != 0) || (sent - c_beats >= 8);
        tick(); cyc++;
      end
      c_pv = 0;
      check("c_all_sent", sent, 128);
      cyc = 0; b0 = c_dones;
      while (c_dones == b0 && cyc < 2000) begin
        c_ready = ($urandom_range(0, 3) != 0);
        tick(); cyc++;
      end
      check("c_done", c_dones - b0, 1);
      check("c_beats", c_beats, 128);
      check("c_eols", c_eols, 8);
      check("c_sof_eof", {c_sofs[7:0], c_eofs[7:0]}, 16'h0101);
      check("c_ovf", c_ovf, 0);
      check("c_queue", qc.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
